// File: rtl/axil_uart_pkg.sv
// Shared register map, status bit positions and engine state encoding
// for the AXI4-Lite UART.
package axil_uart_pkg;

  localparam logic [3:0] REG_RX   = 4'h0;
  localparam logic [3:0] REG_TX   = 4'h4;
  localparam logic [3:0] REG_STAT = 4'h8;
  localparam logic [3:0] REG_CTRL = 4'hC;

  localparam int STAT_RX_VALID  = 0;
  localparam int STAT_RX_FULL   = 1;
  localparam int STAT_TX_EMPTY  = 2;
  localparam int STAT_TX_FULL   = 3;
  localparam int STAT_OVERRUN   = 5;
  localparam int STAT_FRAME_ERR = 6;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } eng_state_e;

endpackage

// File: rtl/axil_uart_fifo.sv
// Synchronous FIFO with show-ahead read data and a synchronous clear.
// Pointers carry one extra wrap bit so full/empty need no extra state.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     clr,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;
  assign rdata = mem[rd_ptr[AW-1:0]];

  // A pop frees the slot in the same cycle, so a full FIFO still accepts a push.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge CLK) begin
    if (RST || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/axil_uart.sv
// AXI4-Lite slave UART: RX/TX byte FIFOs, status/control registers and
// 8N1 serial engines running off a fixed baud divider.
module axil_uart #(
  parameter int BAUD_DIV   = 868,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [3:0]  ARADDR,
  input  logic        ARVALID,
  output logic        ARREADY,
  output logic [31:0] RDATA,
  output logic [1:0]  RRESP,
  output logic        RVALID,
  input  logic        RREADY,
  input  logic [3:0]  AWADDR,
  input  logic        AWVALID,
  output logic        AWREADY,
  input  logic [31:0] WDATA,
  input  logic [3:0]  WSTRB,
  input  logic        WVALID,
  output logic        WREADY,
  output logic [1:0]  BRESP,
  output logic        BVALID,
  input  logic        BREADY,
  output logic        TXD,
  input  logic        RXD
);
  import axil_uart_pkg::*;

  localparam int CW   = $clog2(BAUD_DIV);
  localparam int HALF = BAUD_DIV / 2;
  localparam int FW   = $clog2(FIFO_DEPTH);

  // Handshake rule on every channel: a transfer happens on the rising edge
  // where VALID and READY are both high; VALID never drops before that edge.
  logic        arready_q, rvalid_q, awready_q, bvalid_q;
  logic [31:0] rdata_q, rd_mux, stat;
  logic [3:0]  ar_reg, aw_reg;
  logic        ar_hs, wr_hs, stat_clr;
  logic        overrun, frame_err, overrun_set, frame_set;

  logic        tx_push, tx_pop, tx_clr, tx_full, tx_empty;
  logic [7:0]  tx_rdata;
  logic [FW:0] tx_count;
  logic        rx_push, rx_pop, rx_clr, rx_full, rx_empty;
  logic [7:0]  rx_rdata;
  logic [FW:0] rx_count;

  assign ar_reg   = {ARADDR[3:2], 2'b00};
  assign aw_reg   = {AWADDR[3:2], 2'b00};
  assign ar_hs    = ARVALID && arready_q;
  assign wr_hs    = AWVALID && WVALID && awready_q;
  assign stat_clr = ar_hs && (ar_reg == REG_STAT);
  assign rx_pop   = ar_hs && (ar_reg == REG_RX);
  assign tx_push  = wr_hs && (aw_reg == REG_TX) && WSTRB[0];
  assign tx_clr   = wr_hs && (aw_reg == REG_CTRL) && WDATA[0];
  assign rx_clr   = wr_hs && (aw_reg == REG_CTRL) && WDATA[1];

  always_comb begin
    stat                 = '0;
    stat[STAT_RX_VALID]  = !rx_empty;
    stat[STAT_RX_FULL]   = rx_full;
    stat[STAT_TX_EMPTY]  = tx_empty;
    stat[STAT_TX_FULL]   = tx_full;
    stat[STAT_OVERRUN]   = overrun;
    stat[STAT_FRAME_ERR] = frame_err;
  end

  always_comb begin
    rd_mux = '0;
    case (ar_reg)
      REG_RX:   rd_mux = rx_empty ? 32'h0 : {24'h0, rx_rdata};
      REG_STAT: rd_mux = stat;
      default:  rd_mux = '0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
    end else begin
      arready_q <= ARVALID && !arready_q && !rvalid_q;
      if (ar_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_mux;
      end else if (RREADY) begin
        rvalid_q <= 1'b0;
      end
      awready_q <= AWVALID && WVALID && !bvalid_q && !awready_q;
      if (wr_hs)       bvalid_q <= 1'b1;
      else if (BREADY) bvalid_q <= 1'b0;
    end
  end

  // A new error in the same cycle as the status read survives the clear.
  always_ff @(posedge CLK) begin
    if (RST) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (overrun_set)   overrun <= 1'b1;
      else if (stat_clr) overrun <= 1'b0;
      if (frame_set)     frame_err <= 1'b1;
      else if (stat_clr) frame_err <= 1'b0;
    end
  end

  assign ARREADY = arready_q;
  assign RVALID  = rvalid_q;
  assign RDATA   = rdata_q;
  assign RRESP   = RESP_OKAY;
  assign AWREADY = awready_q;
  assign WREADY  = awready_q;
  assign BVALID  = bvalid_q;
  assign BRESP   = RESP_OKAY;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .CLK(CLK), .RST(RST), .clr(tx_clr), .push(tx_push), .wdata(WDATA[7:0]),
    .pop(tx_pop), .rdata(tx_rdata), .full(tx_full), .empty(tx_empty), .count(tx_count)
  );

  logic [7:0]  rx_shift;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .CLK(CLK), .RST(RST), .clr(rx_clr), .push(rx_push), .wdata(rx_shift),
    .pop(rx_pop), .rdata(rx_rdata), .full(rx_full), .empty(rx_empty), .count(rx_count)
  );

  // ---------------- TX engine ----------------
  eng_state_e  tx_state, tx_next;
  logic [CW-1:0] tx_cnt;
  logic [2:0]  tx_bit;
  logic [7:0]  tx_shift;
  logic        tx_line, txd_q, tx_baud_done;

  assign tx_baud_done = (tx_cnt == CW'(BAUD_DIV - 1));

  always_ff @(posedge CLK) begin
    if (RST) tx_state <= IDLE;
    else     tx_state <= tx_next;
  end

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      IDLE:    if (!tx_empty) tx_next = START;
      START:   if (tx_baud_done) tx_next = DATA;
      DATA:    if (tx_baud_done && (tx_bit == 3'd7)) tx_next = STOP;
      STOP:    if (tx_baud_done) tx_next = tx_empty ? IDLE : START;
      default: tx_next = IDLE;
    endcase
  end

  always_comb begin
    tx_pop  = 1'b0;
    tx_line = 1'b1;
    case (tx_state)
      IDLE:    tx_pop = !tx_empty;
      START:   tx_line = 1'b0;
      DATA:    tx_line = tx_shift[0];
      STOP:    tx_pop = tx_baud_done && !tx_empty;
      default: tx_line = 1'b1;
    endcase
  end

  // TXD is registered, so the start bit lands one edge after the FIFO pop.
  always_ff @(posedge CLK) begin
    if (RST) begin
      txd_q    <= 1'b1;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
    end else begin
      txd_q <= tx_line;
      if (tx_pop) begin
        tx_shift <= tx_rdata;
        tx_cnt   <= '0;
        tx_bit   <= '0;
      end else if (tx_state != IDLE) begin
        if (tx_baud_done) begin
          tx_cnt <= '0;
          if (tx_state == DATA) begin
            tx_shift <= {1'b0, tx_shift[7:1]};
            tx_bit   <= tx_bit + 3'd1;
          end
        end else begin
          tx_cnt <= tx_cnt + CW'(1);
        end
      end
    end
  end

  assign TXD = txd_q;

  // ---------------- RX engine ----------------
  eng_state_e  rx_state, rx_next;
  logic [CW-1:0] rx_cnt;
  logic [2:0]  rx_bit;
  logic        rx_meta, rx_sync, rx_prev;
  logic        rx_baud_done, rx_half_done, rx_tick, rx_stop_sample;

  assign rx_baud_done = (rx_cnt == CW'(BAUD_DIV - 1));
  assign rx_half_done = (rx_cnt == CW'(HALF - 1));
  assign rx_tick      = (rx_state == START) ? rx_half_done : rx_baud_done;

  always_ff @(posedge CLK) begin
    if (RST) rx_state <= IDLE;
    else     rx_state <= rx_next;
  end

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      IDLE:    if (rx_prev && !rx_sync) rx_next = START;
      START:   if (rx_half_done) rx_next = rx_sync ? IDLE : DATA;
      DATA:    if (rx_baud_done && (rx_bit == 3'd7)) rx_next = STOP;
      STOP:    if (rx_baud_done) rx_next = IDLE;
      default: rx_next = IDLE;
    endcase
  end

  always_comb begin
    rx_stop_sample = (rx_state == STOP) && rx_baud_done;
    rx_push        = rx_stop_sample && rx_sync;
    frame_set      = rx_stop_sample && !rx_sync;
    overrun_set    = rx_push && rx_full && !rx_pop && !rx_clr;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
      rx_prev  <= 1'b1;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_meta <= RXD;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
      if (rx_state == IDLE) begin
        rx_cnt <= '0;
        rx_bit <= '0;
      end else if (rx_tick) begin
        rx_cnt <= '0;
        if (rx_state == DATA) begin
          rx_shift <= {rx_sync, rx_shift[7:1]};
          rx_bit   <= rx_bit + 3'd1;
        end
      end else begin
        rx_cnt <= rx_cnt + CW'(1);
      end
    end
  end

  logic unused_bits;
  assign unused_bits = ^{ARADDR[1:0], AWADDR[1:0], WDATA[31:8], WSTRB[3:1], tx_count, rx_count};

endmodule
